// File: rtl/grade_avg_ctrl_if.sv
// grade_avg_ctrl_if: bundle between the grade entry front-end and whoever
// drives the switches/buttons and watches the 7-segment decoder inputs.
//   grade_in  : grade on switches (GW bits)
//   enter     : level, rising edge submits grade_in
//   finish    : level, rising edge ends entry early
//   clear     : level, synchronous return to IDLE
//   code      : 6-bit decoder value {2'b0, digit}
//   classifier: 1 = decoder shows P/F/A class of code
//   valid     : average is on code
//   busy      : divider running
//   err       : sticky out-of-range grade flag
//   count     : grades accepted so far
// master = stimulus side, slave = grade_avg_ctrl.
interface grade_avg_ctrl_if #(
  parameter int GW   = 4,
  parameter int CNTW = 3
);
  logic [GW-1:0]   grade_in;
  logic            enter;
  logic            finish;
  logic            clear;
  logic [5:0]      code;
  logic            classifier;
  logic            valid;
  logic            busy;
  logic            err;
  logic [CNTW-1:0] count;

  modport master (
    output grade_in, enter, finish, clear,
    input  code, classifier, valid, busy, err, count
  );

  modport slave (
    input  grade_in, enter, finish, clear,
    output code, classifier, valid, busy, err, count
  );
endinterface

// File: rtl/grade_avg_ctrl.sv
// grade_avg_ctrl: collects up to NGRADES grades (0..10), one per rising edge
// of enter, then computes floor(sum/count) with a one-subtraction-per-cycle
// divider and presents it to the 7-segment grade decoder.
// Ports:
//   clk_2 : system clock
//   rst_n : asynchronous active-low reset
//   bus   : grade_avg_ctrl_if.slave (switch/button inputs, decoder outputs)
// While collecting, code echoes the last accepted digit (classifier=0); once
// the average is ready, code carries the average with classifier=1, valid=1.
module grade_avg_ctrl #(
  parameter  int NGRADES = 4,
  parameter  int GW      = 4,
  localparam int CNTW    = $clog2(NGRADES + 1),
  localparam int SUMW    = GW + $clog2(NGRADES + 1)
) (
  input  logic              clk_2,
  input  logic              rst_n,
  grade_avg_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DIVIDE  = 2'd2,
    S_SHOW    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [SUMW-1:0] sum_q, sum_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [GW-1:0]   quot_q, quot_d;
  logic [SUMW-1:0] rem_q, rem_d;
  logic [5:0]      code_q, code_d;
  logic            classifier_q, classifier_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic            enter_q, enter_d;
  logic            finish_q, finish_d;

  logic            accept_e_s;
  logic            accept_f_s;
  logic            grade_ok_s;
  logic [SUMW-1:0] sum_acc_s;
  logic [CNTW-1:0] cnt_acc_s;
  logic            go_div_s;

  // Rising-edge events: a held level yields exactly one event.
  assign accept_e_s = bus.enter & ~enter_q;
  assign accept_f_s = bus.finish & ~finish_q;
  assign grade_ok_s = (bus.grade_in <= GW'(4'd10));

  // Next-state and next-output computation for the whole controller.
  always_comb begin
    state_d      = state_q;
    sum_d        = sum_q;
    count_d      = count_q;
    quot_d       = quot_q;
    rem_d        = rem_q;
    code_d       = code_q;
    classifier_d = classifier_q;
    valid_d      = valid_q;
    busy_d       = busy_q;
    err_d        = err_q;
    enter_d      = bus.enter;
    finish_d     = bus.finish;
    sum_acc_s    = sum_q;
    cnt_acc_s    = count_q;
    go_div_s     = 1'b0;

    if (bus.clear) begin
      // clear beats everything; the edge registers keep tracking above.
      state_d      = S_IDLE;
      sum_d        = {SUMW{1'b0}};
      count_d      = {CNTW{1'b0}};
      quot_d       = {GW{1'b0}};
      rem_d        = {SUMW{1'b0}};
      code_d       = 6'd0;
      classifier_d = 1'b0;
      valid_d      = 1'b0;
      busy_d       = 1'b0;
      err_d        = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_COLLECT: begin
          // The grade is handled first so that a simultaneous finish sees
          // the updated count.
          if (accept_e_s && grade_ok_s) begin
            sum_acc_s    = sum_q + SUMW'(bus.grade_in);
            cnt_acc_s    = count_q + CNTW'(1'b1);
            code_d       = {2'b00, bus.grade_in};
            classifier_d = 1'b0;
            state_d      = S_COLLECT;
          end else if (accept_e_s) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          sum_d   = sum_acc_s;
          count_d = cnt_acc_s;

          // Count is zero in IDLE unless a grade was just accepted, so a
          // lone finish in IDLE never reaches the divider.
          if (accept_e_s && grade_ok_s && (cnt_acc_s == CNTW'(NGRADES))) begin
            go_div_s = 1'b1;
          end else if (accept_f_s && (cnt_acc_s != {CNTW{1'b0}})) begin
            go_div_s = 1'b1;
          end else begin
            go_div_s = 1'b0;
          end

          if (go_div_s) begin
            state_d = S_DIVIDE;
            rem_d   = sum_acc_s;
            quot_d  = {GW{1'b0}};
            busy_d  = 1'b1;
          end else begin
            busy_d  = busy_q;
          end
        end

        S_DIVIDE: begin
          // One subtraction per cycle; the failing compare costs one more.
          if (rem_q >= SUMW'(count_q)) begin
            rem_d  = rem_q - SUMW'(count_q);
            quot_d = quot_q + GW'(1'b1);
          end else begin
            state_d      = S_SHOW;
            code_d       = {2'b00, quot_q};
            classifier_d = 1'b1;
            valid_d      = 1'b1;
            busy_d       = 1'b0;
          end
        end

        S_SHOW: begin
          state_d = S_SHOW;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sum_q        <= {SUMW{1'b0}};
      count_q      <= {CNTW{1'b0}};
      quot_q       <= {GW{1'b0}};
      rem_q        <= {SUMW{1'b0}};
      code_q       <= 6'd0;
      classifier_q <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      enter_q      <= 1'b0;
      finish_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sum_q        <= sum_d;
      count_q      <= count_d;
      quot_q       <= quot_d;
      rem_q        <= rem_d;
      code_q       <= code_d;
      classifier_q <= classifier_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      enter_q      <= enter_d;
      finish_q     <= finish_d;
    end
  end

  assign bus.code       = code_q;
  assign bus.classifier = classifier_q;
  assign bus.valid      = valid_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;
  assign bus.count      = count_q;

endmodule

// File: tb/tb_grade_avg_ctrl.sv
// Scoreboard bench for grade_avg_ctrl: stimulus tasks update a list-based
// model of the grade session and queue the expected digit echoes and final
// averages; a monitor pops and compares whenever the DUT shows a new grade
// (count increments) or a new result (valid rises).
module tb_grade_avg_ctrl;
  localparam int NG   = 4;
  localparam int GW   = 4;
  localparam int CNTW = $clog2(NG + 1);

  logic clk_2 = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_2 = ~clk_2;

  grade_avg_ctrl_if #(.GW(GW), .CNTW(CNTW)) bus ();

  grade_avg_ctrl #(.NGRADES(NG), .GW(GW)) dut (
    .clk_2 (clk_2),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { int code; int cnt; } digit_t;
  typedef struct { int avg; int cnt; bit err; } res_t;

  digit_t digit_q[$];
  res_t   res_q[$];
  int     checks   = 0;
  int     failures = 0;

  // model of the session
  int m_grades[$];
  bit m_err  = 1'b0;
  bit m_open = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_2);
    #1;
  endtask

  task automatic model_result;
    int sum;
    sum = 0;
    foreach (m_grades[i]) sum += m_grades[i];
    res_q.push_back('{sum / m_grades.size(), m_grades.size(), m_err});
    m_open = 1'b0;
  endtask

  task automatic model_enter(input int g);
    if (m_open) begin
      if (g > 10) m_err = 1'b1;
      else begin
        m_grades.push_back(g);
        digit_q.push_back('{g, m_grades.size()});
        if (m_grades.size() == NG) model_result();
      end
    end
  endtask

  task automatic model_finish;
    if (m_open && m_grades.size() > 0) model_result();
  endtask

  task automatic model_reset;
    m_grades.delete();
    m_err  = 1'b0;
    m_open = 1'b1;
  endtask

  task automatic pulse_enter(input int g);
    tick();
    bus.grade_in = GW'(g);
    bus.enter    = 1'b1;
    model_enter(g);
    tick();
    bus.enter = 1'b0;
  endtask

  task automatic pulse_finish;
    tick();
    bus.finish = 1'b1;
    model_finish();
    tick();
    bus.finish = 1'b0;
  endtask

  task automatic pulse_both(input int g);
    tick();
    bus.grade_in = GW'(g);
    bus.enter    = 1'b1;
    bus.finish   = 1'b1;
    model_enter(g);
    model_finish();
    tick();
    bus.enter  = 1'b0;
    bus.finish = 1'b0;
  endtask

  task automatic do_clear;
    tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    model_reset();
  endtask

  task automatic wait_result;
    int n;
    n = 0;
    while (!bus.valid && n < 200) begin
      tick();
      n++;
    end
    if (!bus.valid) begin
      checks++;
      failures++;
      $display("FAIL result_timeout valid=%0b expected 1 within 200 cycles", bus.valid);
    end
    tick();
  endtask

  // Monitor: compares DUT outputs against queued expectations.
  initial begin : monitor
    logic [CNTW-1:0] prev_cnt;
    logic            prev_valid;
    logic            prev_busy;
    int              busy_len;
    digit_t          d;
    res_t            r;
    prev_cnt   = '0;
    prev_valid = 1'b0;
    prev_busy  = 1'b0;
    busy_len   = 0;
    forever begin
      @(negedge clk_2);
      if (!rst_n) begin
        prev_cnt   = '0;
        prev_valid = 1'b0;
        prev_busy  = 1'b0;
        busy_len   = 0;
      end else begin
        if (bus.busy && !prev_busy) busy_len = 1;
        else if (bus.busy) busy_len++;
        if (bus.count > prev_cnt) begin
          if (digit_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_grade count=%0d expected no new grade", bus.count);
          end else begin
            d = digit_q.pop_front();
            chk("digit_code", bus.code, d.code);
            chk("digit_count", bus.count, d.cnt);
            chk("digit_class", bus.classifier, 0);
          end
        end
        if (bus.valid && !prev_valid) begin
          if (res_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result code=%0d expected no result", bus.code);
          end else begin
            r = res_q.pop_front();
            chk("avg_code", bus.code, r.avg);
            chk("avg_class", bus.classifier, 1);
            chk("avg_count", bus.count, r.cnt);
            chk("avg_err", bus.err, int'(r.err));
            chk("avg_busy_now", bus.busy, 0);
            chk("busy_cycles", busy_len, r.avg + 1);
          end
        end
        prev_cnt   = bus.count;
        prev_valid = bus.valid;
        prev_busy  = bus.busy;
      end
    end
  end

  initial begin : stimulus
    int ops;
    int r;
    bus.grade_in = '0;
    bus.enter    = 1'b0;
    bus.finish   = 1'b0;
    bus.clear    = 1'b0;

    // reset state
    repeat (3) @(posedge clk_2);
    #1;
    chk("rst_code", bus.code, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_count", bus.count, 0);
    chk("post_rst_err", bus.err, 0);
    chk("post_rst_class", bus.classifier, 0);

    // full session: 7,8,6,7 -> 7
    pulse_enter(7); pulse_enter(8); pulse_enter(6); pulse_enter(7);
    wait_result();

    // early finish: 3,5 -> 4
    do_clear();
    pulse_enter(3); pulse_enter(5); pulse_finish();
    wait_result();

    // out-of-range grade in COLLECT
    do_clear();
    pulse_enter(2);
    pulse_enter(12);
    tick();
    chk("reject_err", bus.err, 1);
    chk("reject_count", bus.count, 1);
    chk("reject_code", bus.code, 2);
    pulse_finish();
    wait_result();
    chk("err_sticky", bus.err, 1);
    do_clear();
    chk("clear_err", bus.err, 0);
    chk("clear_valid", bus.valid, 0);
    chk("clear_count", bus.count, 0);

    // held enter produces one grade
    tick();
    bus.grade_in = GW'(5);
    bus.enter    = 1'b1;
    model_enter(5);
    repeat (10) tick();
    bus.enter = 1'b0;
    tick();
    chk("held_enter_count", bus.count, 1);

    // enter+finish together: 10 then 9 -> 9
    do_clear();
    pulse_enter(10);
    pulse_both(9);
    wait_result();

    // reset during DIVIDE
    do_clear();
    pulse_enter(10); pulse_enter(10); pulse_enter(10); pulse_finish();
    repeat (3) tick();
    chk("mid_div_busy", bus.busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_code", bus.code, 0);
    chk("arst_class", bus.classifier, 0);
    chk("arst_valid", bus.valid, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_err", bus.err, 0);
    chk("arst_count", bus.count, 0);
    res_q.delete();
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
    pulse_finish();
    repeat (3) tick();
    chk("idle_finish_count", bus.count, 0);
    chk("idle_finish_busy", bus.busy, 0);
    chk("idle_finish_valid", bus.valid, 0);

    // randomized sessions
    for (int s = 0; s < 40; s++) begin
      do_clear();
      ops = $urandom_range(1, 7);
      for (int k = 0; k < ops; k++) begin
        if (!m_open) break;
        r = $urandom_range(0, 9);
        if (r < 6)      pulse_enter($urandom_range(0, 12));
        else if (r < 8) pulse_finish();
        else            pulse_both($urandom_range(0, 12));
        if ($urandom_range(0, 3) == 0) tick();
      end
      if (m_open && m_grades.size() > 0) pulse_finish();
      if (!m_open) begin
        wait_result();
        // ignored while showing the result
        pulse_enter($urandom_range(0, 10));
        pulse_finish();
        tick();
        chk("show_hold_valid", bus.valid, 1);
      end
    end

    repeat (3) tick();
    chk("digit_q_left", digit_q.size(), 0);
    chk("res_q_left", res_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
